axil_cmd_master: RTL and testbench

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_master_if.sv | 36 +++
 rtl/axil_cmd_master.sv | 166 ++++++++++++++++
 tb/tb_axil_cmd_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_cmd_master_if.sv
// AXI-Lite channel bundle (32-bit address/data) between the command master and its slave.
// Handshake rule on every channel: a transfer happens on a rising edge where valid && ready;
// once valid is high it and its payload stay put until that edge, and ready may depend on valid.
interface AXIL_IF;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport Master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport Slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite initiator: turns one command into one AXI-Lite read or write,
// returns the response on a valid/ready port and keeps saturating completion/error counters.
module axil_cmd_master #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [31:0]          cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_write,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_resp,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [2:0]           dbg_state_o,
    AXIL_IF.Master               axil_if
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 write_q, write_d;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [1:0]           resp_q, resp_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
    logic                 aw_hs, w_hs;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
    endfunction

    assign aw_hs = (state_q == WR) && !aw_done_q && axil_if.awready;
    assign w_hs  = (state_q == WR) && !w_done_q && axil_if.wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_write ? cmd_wdata : '0;
                    wstrb_d   = cmd_write ? cmd_wstrb : '0;
                    write_d   = cmd_write;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    resp_d    = '0;
                    state_d   = cmd_write ? WR : RD_ADDR;
                end
            end
            // AW and W retire independently; the state advances once both flags are registered.
            WR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_done_q && w_done_q) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (axil_if.bvalid) begin
                    resp_d  = axil_if.bresp;
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (axil_if.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (axil_if.rvalid) begin
                    rdata_d = axil_if.rdata;
                    resp_d  = axil_if.rresp;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    if (write_q) wr_cnt_d = sat_inc(wr_cnt_q);
                    else         rd_cnt_d = sat_inc(rd_cnt_q);
                    if (resp_q != 2'b00) err_cnt_d = sat_inc(err_cnt_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign rsp_valid   = (state_q == RSP);
    assign rsp_write   = write_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign wr_count    = wr_cnt_q;
    assign rd_count    = rd_cnt_q;
    assign err_count   = err_cnt_q;
    assign dbg_state_o = state_q;

    assign axil_if.awvalid = (state_q == WR) && !aw_done_q;
    assign axil_if.awaddr  = addr_q;
    assign axil_if.awprot  = 3'b000;
    assign axil_if.wvalid  = (state_q == WR) && !w_done_q;
    assign axil_if.wdata   = wdata_q;
    assign axil_if.wstrb   = wstrb_q;
    assign axil_if.bready  = (state_q == WR_RESP);
    assign axil_if.arvalid = (state_q == RD_ADDR);
    assign axil_if.araddr  = addr_q;
    assign axil_if.arprot  = 3'b000;
    assign axil_if.rready  = (state_q == RD_DATA);
endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: delay-configurable AXI-Lite slave, directed vector table,
// random vectors against a memory/counter reference model, and a reset-in-flight sequence.
module tb_axil_cmd_master;
  localparam int CW = 3;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_write, busy;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [CW-1:0] wr_count, rd_count, err_count;
  logic [2:0] dbg_state;

  AXIL_IF axil();

  axil_cmd_master #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count),
    .dbg_state_o(dbg_state), .axil_if(axil)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_resp_cfg = '0, r_resp_cfg = '0;
  int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  logic aw_got, w_got;
  logic [31:0] s_awaddr, s_wdata, s_araddr, sl_addr, sl_data;
  logic [3:0] s_wstrb, sl_strb;
  logic [31:0] slv_mem [logic [31:0]];

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  assign axil.awready = axil.awvalid && (aw_cnt >= aw_dly);
  assign axil.wready  = axil.wvalid && (w_cnt >= w_dly);
  assign axil.arready = axil.arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      axil.bvalid <= 1'b0; axil.bresp <= '0;
      axil.rvalid <= 1'b0; axil.rdata <= '0; axil.rresp <= '0;
    end else begin
      if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
      if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
      if (axil.awvalid && !axil.awready) aw_cnt <= aw_cnt + 1;
      if (axil.wvalid && !axil.wready) w_cnt <= w_cnt + 1;
      if (axil.arvalid && !axil.arready) ar_cnt <= ar_cnt + 1;
      if (axil.awvalid && axil.awready) begin
        aw_cnt <= 0; aw_got <= 1'b1; s_awaddr <= axil.awaddr;
      end
      if (axil.wvalid && axil.wready) begin
        w_cnt <= 0; w_got <= 1'b1; s_wdata <= axil.wdata; s_wstrb <= axil.wstrb;
      end
      if ((aw_got || (axil.awvalid && axil.awready)) && (w_got || (axil.wvalid && axil.wready))) begin
        sl_addr = aw_got ? s_awaddr : axil.awaddr;
        sl_data = w_got ? s_wdata : axil.wdata;
        sl_strb = w_got ? s_wstrb : axil.wstrb;
        begin
          logic [31:0] cur;
          cur = slv_rd(sl_addr);
          for (int i = 0; i < 4; i++) if (sl_strb[i]) cur[8*i +: 8] = sl_data[8*i +: 8];
          slv_mem[sl_addr] = cur;
        end
        aw_got <= 1'b0; w_got <= 1'b0;
        if (b_dly == 0) begin
          axil.bvalid <= 1'b1; axil.bresp <= b_resp_cfg;
        end else b_wait <= b_dly;
      end
      if (b_wait > 0) begin
        b_wait <= b_wait - 1;
        if (b_wait == 1) begin axil.bvalid <= 1'b1; axil.bresp <= b_resp_cfg; end
      end
      if (axil.arvalid && axil.arready) begin
        ar_cnt <= 0;
        if (r_dly == 0) begin
          axil.rvalid <= 1'b1; axil.rdata <= slv_rd(axil.araddr); axil.rresp <= r_resp_cfg;
        end else begin
          r_wait <= r_dly; s_araddr <= axil.araddr;
        end
      end
      if (r_wait > 0) begin
        r_wait <= r_wait - 1;
        if (r_wait == 1) begin
          axil.rvalid <= 1'b1; axil.rdata <= slv_rd(s_araddr); axil.rresp <= r_resp_cfg;
        end
      end
    end
  end

  // ---------------- bus monitor: valid/payload hold, activity counts ----------------
  int aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0;
  logic p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0] p_wstrb;

  always @(posedge clk) begin
    if (reset) begin
      p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    end else begin
      if (p_aw) check("awvalid_hold", {31'd0, axil.awvalid, axil.awaddr}, {31'd0, 1'b1, p_awaddr});
      if (p_w)  check("wvalid_hold", {27'd0, axil.wvalid, axil.wstrb, axil.wdata}, {27'd0, 1'b1, p_wstrb, p_wdata});
      if (p_ar) check("arvalid_hold", {31'd0, axil.arvalid, axil.araddr}, {31'd0, 1'b1, p_araddr});
      if (axil.awvalid) check("awprot", {61'd0, axil.awprot}, 64'd0);
      if (axil.arvalid) check("arprot", {61'd0, axil.arprot}, 64'd0);
      if (axil.awvalid) aw_hi++;
      if (axil.wvalid) w_hi++;
      if (axil.arvalid) ar_hi++;
      if (axil.bvalid && axil.bready) b_hs++;
      p_aw = axil.awvalid && !axil.awready; p_awaddr = axil.awaddr;
      p_w  = axil.wvalid && !axil.wready;   p_wdata = axil.wdata; p_wstrb = axil.wstrb;
      p_ar = axil.arvalid && !axil.arready; p_araddr = axil.araddr;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  int ref_wr = 0, ref_rd = 0, ref_err = 0;
  logic [34:0] exp_q[$];  // {write, resp, rdata}

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (nw & mask);
  endfunction

  function automatic int sat(input int c);
    return (c >= CNT_SAT) ? CNT_SAT : c + 1;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    int          hold;
    logic        poke;       // offer a second command while the response is held
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_lat;    // 0 = only the minimum bound is checked
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int awd, input int wd, input int bd, input int ard, input int rd,
                              input logic [1:0] rsp, input int hold, input logic poke,
                              input logic chk, input logic [31:0] erd, input int lat);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.aw_d = awd; v.w_d = wd; v.b_d = bd; v.ar_d = ard; v.r_d = rd;
    v.resp = rsp; v.hold = hold; v.poke = poke; v.chk_rdata = chk; v.exp_rdata = erd; v.exp_lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int lat, t;
    logic [34:0] e;
    logic [31:0] hr;
    logic [1:0] hresp;
    logic hw;
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
    b_resp_cfg = v.resp; r_resp_cfg = v.resp;
    if (v.wr) begin
      ref_mem[v.addr] = ref_merge(ref_mem.exists(v.addr) ? ref_mem[v.addr] : 32'h0, v.data, v.strb);
      exp_q.push_back({1'b1, v.resp, 32'h0});
    end else
      exp_q.push_back({1'b0, v.resp, ref_mem.exists(v.addr) ? ref_mem[v.addr] : 32'h0});
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.data; cmd_wstrb = v.strb;
    t = 0;
    while (!cmd_ready && t < 50) begin @(posedge clk); #1; t++; end
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    aw_hi = 0; w_hi = 0; ar_hi = 0; b_hs = 0;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency_min", {63'd0, lat >= (v.wr ? 4 : 3)}, 64'd1);
    if (v.exp_lat != 0) check("latency", lat, v.exp_lat);
    hr = rsp_rdata; hresp = rsp_resp; hw = rsp_write;
    for (int i = 0; i < v.hold; i++) begin
      if (v.poke) begin cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hF0; end
      @(posedge clk); #1;
      check("hold_stable", {29'd0, rsp_valid, cmd_ready, hw, hresp, hr},
                           {29'd0, 1'b1, 1'b0, rsp_write, rsp_resp, rsp_rdata});
    end
    cmd_valid = 1'b0;
    check("rsp_write", {63'd0, rsp_write}, {63'd0, e[34]});
    check("rsp_resp", {62'd0, rsp_resp}, {62'd0, e[33:32]});
    check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e[31:0]});
    if (v.chk_rdata) check("rsp_rdata_tbl", {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (v.wr) ref_wr = sat(ref_wr); else ref_rd = sat(ref_rd);
    if (v.resp != 2'b00) ref_err = sat(ref_err);
    check("wr_count", wr_count, ref_wr);
    check("rd_count", rd_count, ref_rd);
    check("err_count", err_count, ref_err);
    check("idle_after_rsp", {62'd0, cmd_ready, busy}, {62'd0, 1'b1, 1'b0});
    if (v.wr) begin
      check("aw_cycles", aw_hi, v.aw_d + 1);
      check("w_cycles", w_hi, v.w_d + 1);
      check("b_handshakes", b_hs, 1);
      check("no_ar_on_write", ar_hi, 0);
    end else begin
      check("ar_cycles", ar_hi, v.ar_d + 1);
      check("no_aw_on_read", aw_hi + w_hi, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    check("reset_outputs", {47'd0, rsp_valid, busy, axil.awvalid, axil.wvalid, axil.arvalid,
                            axil.bready, axil.rready, wr_count, rd_count, err_count},
          64'd0);
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check("cmd_ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    //          wr    addr     data          strb awd wd bd ard rd resp hold poke chk erd           lat
    tbl.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 0, 1'b0, 1'b0, 32'h0,        4));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 3));
    tbl.push_back(mk(1'b1, 32'h20, 32'h12345678, 4'h5, 2, 0, 0, 0, 0, 2'd0, 0, 1'b0, 1'b0, 32'h0,        0));
    tbl.push_back(mk(1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd2, 0, 1'b0, 1'b1, 32'h00340078, 3));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 5, 1'b1, 1'b1, 32'hDEADBEEF, 3));
    tbl.push_back(mk(1'b1, 32'h10, 32'hA5A5A5A5, 4'h3, 0, 3, 2, 0, 0, 2'd1, 1, 1'b0, 1'b0, 32'h0,        0));
    tbl.push_back(mk(1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 2, 3, 2'd0, 0, 1'b0, 1'b1, 32'hDEADA5A5, 0));
    tbl.push_back(mk(1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 1, 1, 0, 0, 0, 2'd3, 2, 1'b0, 1'b0, 32'h0,        0));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Reset while waiting for the write response: no response, everything cleared.
    begin
      int t;
      aw_dly = 0; w_dly = 0; b_dly = 6; b_resp_cfg = 2'd0;
      ref_mem[32'h30] = ref_merge(ref_mem.exists(32'h30) ? ref_mem[32'h30] : 32'h0, 32'h5555AAAA, 4'hF);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h5555AAAA; cmd_wstrb = 4'hF;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (!axil.bready && t < 50) begin @(posedge clk); #1; t++; end
      check("reached_wr_resp", {63'd0, axil.bready}, 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_outputs", {27'd0, rsp_valid, busy, axil.awvalid, axil.wvalid, axil.arvalid,
                                    axil.bready, axil.rready, rsp_write, rsp_resp, rsp_rdata},
            64'd0);
      check("async_reset_counters", {55'd0, wr_count, rd_count, err_count}, 64'd0);
      @(posedge clk); #3;
      reset = 1'b0;
      ref_wr = 0; ref_rd = 0; ref_err = 0;
      @(posedge clk); #1;
      check("cmd_ready_after_release", {62'd0, cmd_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
      check("counters_after_release", {55'd0, wr_count, rd_count, err_count}, 64'd0);
    end

    // Random traffic over a small address window.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.wr = 1'($urandom_range(0, 1));
      v.addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      v.data = $urandom;
      v.strb = 4'($urandom_range(0, 15));
      v.aw_d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
      v.w_d  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
      v.b_d  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
      v.ar_d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
      v.r_d  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
      v.resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      v.hold = $urandom_range(0, 2);
      v.poke = 1'($urandom_range(0, 1));
      v.chk_rdata = 1'b0;
      v.exp_rdata = '0;
      if (v.wr) v.exp_lat = (v.aw_d == 0 && v.w_d == 0 && v.b_d == 0) ? 4 : 0;
      else      v.exp_lat = (v.ar_d == 0 && v.r_d == 0) ? 3 : 0;
      run_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule
